// File: rtl/control_unit.sv
// Mini SRC hardwired control sequencer.
// Steps one control state per clock: fetch (T0-T2), then the execute steps
// (T3-T7) of the opcode currently held in IR_Data. Strobes are a pure decode
// of the state register and the loaded instruction. T3 already needs the
// opcode, and IR only loads at the T2->T3 edge, so these strobes cannot be
// pre-registered one step ahead.
//
// Input sampling protocol (there are no valid/ready handshakes here):
//   - Stop is sampled only at the edge that ends an instruction's last step.
//   - CON_out is sampled only at the edge that ends T3 of a branch.
//   - clr is sampled at every edge and wins over everything else.
module control_unit #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] ALU_ADD = 5'b00011,
  parameter logic [OPW-1:0] ALU_AND = 5'b00101,
  parameter logic [OPW-1:0] ALU_OR  = 5'b00110
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    IR_Data,
  input  logic           CON_out,
  input  logic           Stop,
  output logic           Run,
  output logic           PC_in,
  output logic           IR_in,
  output logic           Y_in,
  output logic           Z_in,
  output logic           MAR_in,
  output logic           MDR_in,
  output logic           IncPC,
  output logic           PC_out,
  output logic           Zlow_out,
  output logic           MDR_out,
  output logic           C_out,
  output logic           Read,
  output logic           Write,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic [OPW-1:0] alu_instruction_bits,
  output logic [3:0]     state_dbg,
  output logic           taken_dbg
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_HALT = 5'd27;

  state_t         state;
  state_t         boundary_next;
  logic           taken;
  logic [4:0]     opcode;
  logic           is_ld;
  logic           is_ldi;
  logic           is_st;
  logic           is_reg_alu;
  logic           is_imm_alu;
  logic           is_br;
  logic           is_halt;
  logic           is_mem;
  logic [OPW-1:0] imm_code;
  logic           unused_ir_bits;

  assign opcode         = IR_Data[31:27];
  assign unused_ir_bits = ^IR_Data[26:0];
  assign state_dbg      = state;
  assign taken_dbg      = taken;

  // Opcode class decode; anything not matched behaves as nop.
  always_comb begin
    is_ld      = (opcode == OP_LD);
    is_ldi     = (opcode == OP_LDI);
    is_st      = (opcode == OP_ST);
    is_reg_alu = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    is_imm_alu = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    is_br      = (opcode == OP_BR);
    is_halt    = (opcode == OP_HALT);
    is_mem     = is_ld || is_st;
    imm_code   = ALU_ADD;
    if (opcode == OP_ANDI) imm_code = ALU_AND;
    if (opcode == OP_ORI)  imm_code = ALU_OR;
    boundary_next = Stop ? S_HALT : S_T0;
  end

  // Step sequencer and branch-taken flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_RESET;
      taken <= 1'b0;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0: begin
          taken <= 1'b0;
          state <= S_T1;
        end
        S_T1: state <= S_T2;
        S_T2: state <= S_T3;
        S_T3: begin
          if (is_br) taken <= CON_out;
          if (is_halt) begin
            state <= S_HALT;
          end else if (is_mem || is_ldi || is_reg_alu || is_imm_alu || is_br) begin
            state <= S_T4;
          end else begin
            state <= boundary_next;
          end
        end
        S_T4: state <= S_T5;
        S_T5: begin
          if (is_mem || is_br) state <= S_T6;
          else                 state <= boundary_next;
        end
        S_T6: begin
          if (is_mem) state <= S_T7;
          else        state <= boundary_next;
        end
        S_T7:   state <= boundary_next;
        S_HALT: state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Strobe decode from the current step and the loaded opcode.
  always_comb begin
    Run                  = 1'b0;
    PC_in                = 1'b0;
    IR_in                = 1'b0;
    Y_in                 = 1'b0;
    Z_in                 = 1'b0;
    MAR_in               = 1'b0;
    MDR_in               = 1'b0;
    IncPC                = 1'b0;
    PC_out               = 1'b0;
    Zlow_out             = 1'b0;
    MDR_out              = 1'b0;
    C_out                = 1'b0;
    Read                 = 1'b0;
    Write                = 1'b0;
    Gra                  = 1'b0;
    Grb                  = 1'b0;
    Grc                  = 1'b0;
    Rin                  = 1'b0;
    Rout                 = 1'b0;
    BAout                = 1'b0;
    alu_instruction_bits = '0;
    case (state)
      S_T0: begin
        Run    = 1'b1;
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
      end
      S_T1: begin
        Run      = 1'b1;
        Zlow_out = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
      end
      S_T2: begin
        Run     = 1'b1;
        MDR_out = 1'b1;
        IR_in   = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        if (is_mem || is_ldi) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Y_in  = 1'b1;
        end else if (is_reg_alu || is_imm_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Y_in = 1'b1;
        end else if (is_br) begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
      end
      S_T4: begin
        Run = 1'b1;
        if (is_mem || is_ldi) begin
          C_out                = 1'b1;
          Z_in                 = 1'b1;
          alu_instruction_bits = ALU_ADD;
        end else if (is_reg_alu) begin
          Grc                  = 1'b1;
          Rout                 = 1'b1;
          Z_in                 = 1'b1;
          alu_instruction_bits = OPW'(opcode);
        end else if (is_imm_alu) begin
          C_out                = 1'b1;
          Z_in                 = 1'b1;
          alu_instruction_bits = imm_code;
        end else if (is_br) begin
          PC_out = 1'b1;
          Y_in   = 1'b1;
        end
      end
      S_T5: begin
        Run = 1'b1;
        if (is_ldi || is_reg_alu || is_imm_alu) begin
          Zlow_out = 1'b1;
          Gra      = 1'b1;
          Rin      = 1'b1;
        end else if (is_mem) begin
          Zlow_out = 1'b1;
          MAR_in   = 1'b1;
        end else if (is_br) begin
          C_out                = 1'b1;
          Z_in                 = 1'b1;
          alu_instruction_bits = ALU_ADD;
        end
      end
      S_T6: begin
        Run = 1'b1;
        if (is_ld) begin
          Read   = 1'b1;
          MDR_in = 1'b1;
        end else if (is_st) begin
          Gra    = 1'b1;
          Rout   = 1'b1;
          MDR_in = 1'b1;
        end else if (is_br && taken) begin
          Zlow_out = 1'b1;
          PC_in    = 1'b1;
        end
      end
      S_T7: begin
        Run = 1'b1;
        if (is_ld) begin
          MDR_out = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: begin
        Run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction table, hand-written Stop/clr
// sequences, then random instructions checked against an instruction-level
// model that lists each instruction's expected strobe words.
module tb_control_unit;

  logic        clk;
  logic        clr;
  logic [31:0] ir_data;
  logic        con_out;
  logic        stop;
  logic        run, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, inc_pc;
  logic        pc_out, zlow_out, mdr_out, c_out, read, write;
  logic        gra, grb, grc, rin, rout, ba_out;
  logic [4:0]  alu;
  logic [3:0]  state_dbg;
  logic        taken_dbg;

  int n_checks;
  int n_errors;

  // Expected output words: [24:20] alu code, [19] Run, [18:0] strobes.
  localparam logic [24:0] RUN  = 25'(1) << 19;
  localparam logic [24:0] PCI  = 25'(1) << 18;
  localparam logic [24:0] IRI  = 25'(1) << 17;
  localparam logic [24:0] YI   = 25'(1) << 16;
  localparam logic [24:0] ZI   = 25'(1) << 15;
  localparam logic [24:0] MARI = 25'(1) << 14;
  localparam logic [24:0] MDRI = 25'(1) << 13;
  localparam logic [24:0] INC  = 25'(1) << 12;
  localparam logic [24:0] PCO  = 25'(1) << 11;
  localparam logic [24:0] ZLO  = 25'(1) << 10;
  localparam logic [24:0] MDRO = 25'(1) << 9;
  localparam logic [24:0] CO   = 25'(1) << 8;
  localparam logic [24:0] RD   = 25'(1) << 7;
  localparam logic [24:0] WR   = 25'(1) << 6;
  localparam logic [24:0] GRA  = 25'(1) << 5;
  localparam logic [24:0] GRB  = 25'(1) << 4;
  localparam logic [24:0] GRC  = 25'(1) << 3;
  localparam logic [24:0] RIN  = 25'(1) << 2;
  localparam logic [24:0] ROUT = 25'(1) << 1;
  localparam logic [24:0] BAO  = 25'(1);
  localparam logic [24:0] NONE = 25'(0);

  localparam logic [24:0] F0 = RUN | PCO | MARI | INC | ZI;
  localparam logic [24:0] F1 = RUN | ZLO | PCI | RD | MDRI;
  localparam logic [24:0] F2 = RUN | MDRO | IRI;

  localparam logic [4:0] C_ADD = 5'b00011;
  localparam logic [4:0] C_AND = 5'b00101;
  localparam logic [4:0] C_OR  = 5'b00110;

  typedef struct packed {
    logic [31:0]       ir;
    logic              con;
    logic [2:0]        len;
    logic [4:0][24:0]  ex;
  } vec_t;

  vec_t vecs [12];
  logic [24:0] exp_q[$];

  control_unit dut (
    .clk(clk), .clr(clr), .IR_Data(ir_data), .CON_out(con_out), .Stop(stop),
    .Run(run), .PC_in(pc_in), .IR_in(ir_in), .Y_in(y_in), .Z_in(z_in),
    .MAR_in(mar_in), .MDR_in(mdr_in), .IncPC(inc_pc), .PC_out(pc_out),
    .Zlow_out(zlow_out), .MDR_out(mdr_out), .C_out(c_out), .Read(read),
    .Write(write), .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout),
    .BAout(ba_out), .alu_instruction_bits(alu), .state_dbg(state_dbg),
    .taken_dbg(taken_dbg)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] alu_w(input logic [4:0] c);
    return {c, 20'b0};
  endfunction

  function automatic logic [24:0] actual();
    return {alu, run, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, inc_pc, pc_out,
            zlow_out, mdr_out, c_out, read, write, gra, grb, grc, rin, rout, ba_out};
  endfunction

  task automatic check(input string name, input logic [24:0] exp);
    logic [24:0] got;
    got = actual();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    r = $urandom();
    ir_data = r;
    con_out = 1'($urandom_range(0, 1));
    stop    = 1'($urandom_range(0, 1));
  endtask

  // Two clocks of clr, then release; returns positioned in T0.
  task automatic do_reset();
    clr = 1'b1;
    tick();
    check("reset_1", NONE);
    rand_inputs();
    tick();
    check("reset_2", NONE);
    clr = 1'b0;
    stop = 1'b0;
    tick();
  endtask

  // HALT holds with all outputs 0 regardless of Stop/CON_out/IR_Data.
  task automatic check_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check($sformatf("halt_%0d", i), NONE);
      rand_inputs();
      tick();
    end
  endtask

  // Plays exp_q step by step starting in T0. IR_Data carries random bits
  // during fetch and the instruction from T3 on; CON_out and Stop are random
  // except at the edges where they matter.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con_t3,
                           input logic stop_b, input int stop_from, input int abort_at);
    int n;
    logic [31:0] r;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_step%0d", name, k), exp_q.pop_front());
      r = $urandom();
      ir_data = (k >= 2) ? ir : r;
      con_out = (k == 3) ? con_t3 : 1'($urandom_range(0, 1));
      if (k >= stop_from)  stop = 1'b1;
      else if (k == n - 1) stop = stop_b;
      else                 stop = 1'($urandom_range(0, 1));
      if (k == abort_at) begin
        clr = 1'b1;
        tick();
        check($sformatf("%s_abort", name), NONE);
        exp_q.delete();
        return;
      end
      tick();
    end
    stop = 1'b0;
  endtask

  // Instruction-level reference: the full list of strobe words one
  // instruction produces, fetch included.
  task automatic model_push(input logic [4:0] op, input logic con);
    exp_q.push_back(F0);
    exp_q.push_back(F1);
    exp_q.push_back(F2);
    if (op <= 5'd2) begin
      exp_q.push_back(RUN | GRB | BAO | YI);
      exp_q.push_back(RUN | CO | ZI | alu_w(C_ADD));
      if (op == 5'd1) begin
        exp_q.push_back(RUN | ZLO | GRA | RIN);
      end else begin
        exp_q.push_back(RUN | ZLO | MARI);
        if (op == 5'd0) begin
          exp_q.push_back(RUN | RD | MDRI);
          exp_q.push_back(RUN | MDRO | GRA | RIN);
        end else begin
          exp_q.push_back(RUN | GRA | ROUT | MDRI);
          exp_q.push_back(RUN | WR);
        end
      end
    end else if (op <= 5'd11) begin
      exp_q.push_back(RUN | GRB | ROUT | YI);
      exp_q.push_back(RUN | GRC | ROUT | ZI | alu_w(op));
      exp_q.push_back(RUN | ZLO | GRA | RIN);
    end else if (op <= 5'd14) begin
      exp_q.push_back(RUN | GRB | ROUT | YI);
      exp_q.push_back(RUN | CO | ZI | alu_w(op == 5'd12 ? C_ADD : (op == 5'd13 ? C_AND : C_OR)));
      exp_q.push_back(RUN | ZLO | GRA | RIN);
    end else if (op == 5'd19) begin
      exp_q.push_back(RUN | GRA | ROUT);
      exp_q.push_back(RUN | PCO | YI);
      exp_q.push_back(RUN | CO | ZI | alu_w(C_ADD));
      exp_q.push_back(con ? (RUN | ZLO | PCI) : RUN);
    end else begin
      exp_q.push_back(RUN);
    end
  endtask

  task automatic set_vec(input int idx, input logic [31:0] ir, input logic con,
                         input logic [2:0] len, input logic [24:0] t3, input logic [24:0] t4,
                         input logic [24:0] t5, input logic [24:0] t6, input logic [24:0] t7);
    vecs[idx].ir  = ir;
    vecs[idx].con = con;
    vecs[idx].len = len;
    vecs[idx].ex  = {t7, t6, t5, t4, t3};
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    logic        con;
    logic        stp;

    n_checks = 0;
    n_errors = 0;
    clr      = 1'b1;
    ir_data  = 32'h0;
    con_out  = 1'b0;
    stop     = 1'b0;

    // Directed vectors: instruction, branch condition, execute-step words.
    set_vec(0,  32'h08800075, 1'b0, 3'd3, RUN|GRB|BAO|YI, RUN|CO|ZI|alu_w(5'd3),
            RUN|ZLO|GRA|RIN, NONE, NONE);
    set_vec(1,  32'h00800014, 1'b0, 3'd5, RUN|GRB|BAO|YI, RUN|CO|ZI|alu_w(5'd3),
            RUN|ZLO|MARI, RUN|RD|MDRI, RUN|MDRO|GRA|RIN);
    set_vec(2,  32'h10000000, 1'b1, 3'd5, RUN|GRB|BAO|YI, RUN|CO|ZI|alu_w(5'd3),
            RUN|ZLO|MARI, RUN|GRA|ROUT|MDRI, RUN|WR);
    set_vec(3,  32'h98000004, 1'b1, 3'd4, RUN|GRA|ROUT, RUN|PCO|YI,
            RUN|CO|ZI|alu_w(5'd3), RUN|ZLO|PCI, NONE);
    set_vec(4,  32'h98000004, 1'b0, 3'd4, RUN|GRA|ROUT, RUN|PCO|YI,
            RUN|CO|ZI|alu_w(5'd3), RUN, NONE);
    set_vec(5,  32'h18918000, 1'b1, 3'd3, RUN|GRB|ROUT|YI, RUN|GRC|ROUT|ZI|alu_w(5'd3),
            RUN|ZLO|GRA|RIN, NONE, NONE);
    set_vec(6,  32'h58918000, 1'b0, 3'd3, RUN|GRB|ROUT|YI, RUN|GRC|ROUT|ZI|alu_w(5'd11),
            RUN|ZLO|GRA|RIN, NONE, NONE);
    set_vec(7,  32'h60900005, 1'b0, 3'd3, RUN|GRB|ROUT|YI, RUN|CO|ZI|alu_w(5'd3),
            RUN|ZLO|GRA|RIN, NONE, NONE);
    set_vec(8,  32'h68900005, 1'b0, 3'd3, RUN|GRB|ROUT|YI, RUN|CO|ZI|alu_w(5'd5),
            RUN|ZLO|GRA|RIN, NONE, NONE);
    set_vec(9,  32'h70900005, 1'b1, 3'd3, RUN|GRB|ROUT|YI, RUN|CO|ZI|alu_w(5'd6),
            RUN|ZLO|GRA|RIN, NONE, NONE);
    set_vec(10, 32'hD0000000, 1'b1, 3'd1, RUN, NONE, NONE, NONE, NONE);
    set_vec(11, 32'hA0000000, 1'b1, 3'd1, RUN, NONE, NONE, NONE, NONE);

    do_reset();

    for (int v = 0; v < 12; v++) begin
      exp_q = {F0, F1, F2};
      for (int j = 0; j < int'(vecs[v].len); j++) exp_q.push_back(vecs[v].ex[j]);
      run_instr($sformatf("vec%0d", v), vecs[v].ir, vecs[v].con, 1'b0, 99, 99);
    end

    // Stop raised in T4 of an add and held: finishes T5, then HALT.
    exp_q = {F0, F1, F2, RUN|GRB|ROUT|YI, RUN|GRC|ROUT|ZI|alu_w(5'd3), RUN|ZLO|GRA|RIN};
    run_instr("stop_add", 32'h18918000, 1'b0, 1'b1, 4, 99);
    check_halt(4);
    do_reset();

    // halt opcode enters HALT with Stop low.
    exp_q = {F0, F1, F2, RUN};
    run_instr("halt_op", 32'hD8000000, 1'b0, 1'b0, 99, 99);
    check_halt(3);
    do_reset();

    // clr during T6 of ld: RESET on the next clock, Read gone.
    exp_q = {F0, F1, F2, RUN|GRB|BAO|YI, RUN|CO|ZI|alu_w(5'd3), RUN|ZLO|MARI, RUN|RD|MDRI};
    run_instr("clr_ld", 32'h00800014, 1'b0, 1'b0, 99, 6);
    clr  = 1'b0;
    stop = 1'b0;
    tick();

    // Random instruction stream against the model.
    for (int i = 0; i < 80; i++) begin
      r   = $urandom();
      op  = 5'($urandom_range(0, 31));
      con = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 7) == 0);
      model_push(op, con);
      run_instr($sformatf("rnd%0d_op%0d", i, op), {op, r[26:0]}, con, stp, 99, 99);
      if (stp || op == 5'd27) begin
        check_halt(2);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
